// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing constants, RGB444 pixel type and colour-bar palette.
// Pure declarations: no latency, no flow control.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Left-to-right bar order: white, yellow, cyan, green, magenta, red, blue, black.
    localparam rgb444_t BAR_COLOURS [8] = '{
        '{r: 4'hF, g: 4'hF, b: 4'hF},
        '{r: 4'hF, g: 4'hF, b: 4'h0},
        '{r: 4'h0, g: 4'hF, b: 4'hF},
        '{r: 4'h0, g: 4'hF, b: 4'h0},
        '{r: 4'hF, g: 4'h0, b: 4'hF},
        '{r: 4'hF, g: 4'h0, b: 4'h0},
        '{r: 4'h0, g: 4'h0, b: 4'hF},
        '{r: 4'h0, g: 4'h0, b: 4'h0}
    };

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle between the timing generator and the DAC / pixel source.
// Latency and flow control are defined by the driver; the pixel strobe is the only input.
interface vga_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10
) ();
    logic          pix_en_i;
    logic          hsync_o;
    logic          vsync_o;
    logic          active_video_o;
    logic [XW-1:0] x_o;
    logic [YW-1:0] y_o;
    logic          line_start_o;
    logic          frame_start_o;
    logic [3:0]    pat_r_o;
    logic [3:0]    pat_g_o;
    logic [3:0]    pat_b_o;

    modport master (
        input  pix_en_i,
        output hsync_o, vsync_o, active_video_o, x_o, y_o,
        output line_start_o, frame_start_o, pat_r_o, pat_g_o, pat_b_o
    );

    modport slave (
        output pix_en_i,
        input  hsync_o, vsync_o, active_video_o, x_o, y_o,
        input  line_start_o, frame_start_o, pat_r_o, pat_g_o, pat_b_o
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with combinational active/sync/wrap decode of the current count.
// Count advances on the clock after inc; no backpressure, inc is a pure enable.
module vga_axis_counter #(
    parameter  int ACTIVE = 640,
    parameter  int FP     = 16,
    parameter  int SYNC   = 96,
    parameter  int BP     = 48,
    localparam int TOTAL  = ACTIVE + FP + SYNC + BP,
    localparam int W      = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         active,
    output logic         sync,
    output logic         wrap
);

    logic at_end;

    assign at_end = (count == W'(TOTAL - 1));
    assign wrap   = inc && at_end;
    assign active = (count < W'(ACTIVE));
    assign sync   = (count >= W'(ACTIVE + FP)) && (count < W'(ACTIVE + FP + SYNC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= at_end ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator; all outputs registered one clock after the counter value, holding between pix_en strobes.
// No backpressure. Optional colour bars built only with VGA_TIMING_PATTERN_EN defined.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);

    if (H_ACTIVE % 8 != 0) begin : g_bad_h_active
        $error("H_ACTIVE must be a multiple of 8");
    end
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_widths
        $error("porch and sync widths must be at least 1");
    end

    logic          pix_en;
    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic          h_act, h_sync, h_wrap;
    logic          v_act, v_sync, v_wrap;
    logic          v_top;

    assign pix_en = vga.pix_en_i;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP)
    ) u_h_axis (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .inc    (pix_en),
        .count  (h_cnt),
        .active (h_act),
        .sync   (h_sync),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP)
    ) u_v_axis (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .inc    (h_wrap),
        .count  (v_cnt),
        .active (v_act),
        .sync   (v_sync),
        .wrap   (v_wrap)
    );

    // Tracks "current line is row 0" from the vertical wrap instead of a full-width compare.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_top <= 1'b1;
        end else if (h_wrap) begin
            v_top <= v_wrap;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vga.hsync_o        <= ~HSYNC_POL;
            vga.vsync_o        <= ~VSYNC_POL;
            vga.active_video_o <= 1'b0;
            vga.x_o            <= '0;
            vga.y_o            <= '0;
            vga.line_start_o   <= 1'b0;
            vga.frame_start_o  <= 1'b0;
        end else begin
            vga.line_start_o  <= pix_en && (h_cnt == '0);
            vga.frame_start_o <= pix_en && (h_cnt == '0) && v_top;
            if (pix_en) begin
                vga.hsync_o        <= h_sync ? HSYNC_POL : ~HSYNC_POL;
                vga.vsync_o        <= v_sync ? VSYNC_POL : ~VSYNC_POL;
                vga.active_video_o <= h_act && v_act;
                vga.x_o            <= h_cnt;
                vga.y_o            <= v_cnt;
            end
        end
    end

`ifdef VGA_TIMING_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [BW-1:0] bar_px;
    logic [2:0]    bar_idx;
    rgb444_t       pat_nxt;

    // Bar index tracks the current h; it only needs to be right while h < H_ACTIVE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                bar_px  <= '0;
                bar_idx <= '0;
            end else if (bar_px == BW'(BAR_W - 1)) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px  <= bar_px + BW'(1);
            end
        end
    end

    always_comb begin
        pat_nxt = '0;
        if (h_act && v_act) begin
            pat_nxt = BAR_COLOURS[bar_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vga.pat_r_o <= 4'h0;
            vga.pat_g_o <= 4'h0;
            vga.pat_b_o <= 4'h0;
        end else if (pix_en) begin
            vga.pat_r_o <= pat_nxt.r;
            vga.pat_g_o <= pat_nxt.g;
            vga.pat_b_o <= pat_nxt.b;
        end
    end
`else
    assign vga.pat_r_o = 4'h0;
    assign vga.pat_g_o = 4'h0;
    assign vga.pat_b_o = 4'h0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Drives two generators (default 640x480 and a small high-polarity raster) and checks every clock against a pixel-index model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.XW(10), .YW(10)) vga0 ();
    vga_timing_gen_if #(.XW(7),  .YW(5))  vga1 ();

    assign vga0.pix_en_i = pix_en;
    assign vga1.pix_en_i = pix_en;

    vga_timing_gen u_dut0 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .vga    (vga0)
    );

    vga_timing_gen #(
        .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (12), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
    ) u_dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .vga    (vga1)
    );

    longint k;       // strobes accepted since the last reset
    bit     last;    // previous clock edge carried an accepted strobe
    int     n_vec;
    int     n_err;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs are derived from the pixel index k-1 alone.
    task automatic check_px(
        input string nm,
        input int ha, input int hf, input int hs, input int hb,
        input int va, input int vf, input int vs, input int vb,
        input bit hpol, input bit vpol,
        input logic hs_o, input logic vs_o, input logic av_o,
        input int xo, input int yo,
        input logic ls_o, input logic fs_o,
        input logic [3:0] r_o, input logic [3:0] g_o, input logic [3:0] b_o);
        int ht, vt, x, y, bar;
        longint p;
        bit av, ehs, evs, els, efs;
        logic [3:0] er, eg, eb;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        er = 4'h0; eg = 4'h0; eb = 4'h0;
        if (k == 0) begin
            x = 0; y = 0; av = 0; els = 0; efs = 0;
            ehs = !hpol; evs = !vpol;
        end else begin
            p   = k - 1;
            x   = int'(p % ht);
            y   = int'((p / ht) % vt);
            av  = (x < ha) && (y < va);
            ehs = (x >= ha + hf && x < ha + hf + hs) ? hpol : !hpol;
            evs = (y >= va + vf && y < va + vf + vs) ? vpol : !vpol;
            els = last && (x == 0);
            efs = last && (x == 0) && (y == 0);
`ifdef VGA_TIMING_PATTERN_EN
            if (av) begin
                bar = x / (ha / 8);
                er  = (bar[1] == 1'b0) ? 4'hF : 4'h0;
                eg  = (bar < 4)        ? 4'hF : 4'h0;
                eb  = (bar[0] == 1'b0) ? 4'hF : 4'h0;
            end
`endif
        end
        chk({nm, ".x"},     xo,   x);
        chk({nm, ".y"},     yo,   y);
        chk({nm, ".hsync"}, hs_o, ehs);
        chk({nm, ".vsync"}, vs_o, evs);
        chk({nm, ".active"}, av_o, av);
        chk({nm, ".line_start"},  ls_o, els);
        chk({nm, ".frame_start"}, fs_o, efs);
        chk({nm, ".pat_r"}, r_o, er);
        chk({nm, ".pat_g"}, g_o, eg);
        chk({nm, ".pat_b"}, b_o, eb);
    endtask

    task automatic check_all();
        check_px("d0", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
                 vga0.hsync_o, vga0.vsync_o, vga0.active_video_o,
                 int'(vga0.x_o), int'(vga0.y_o), vga0.line_start_o, vga0.frame_start_o,
                 vga0.pat_r_o, vga0.pat_g_o, vga0.pat_b_o);
        check_px("d1", 64, 4, 8, 4, 12, 2, 2, 3, 1'b1, 1'b1,
                 vga1.hsync_o, vga1.vsync_o, vga1.active_video_o,
                 int'(vga1.x_o), int'(vga1.y_o), vga1.line_start_o, vga1.frame_start_o,
                 vga1.pat_r_o, vga1.pat_g_o, vga1.pat_b_o);
    endtask

    // Apply one clock with the given strobe; inputs change on the falling edge, outputs checked there too.
    task automatic tick(input bit en);
        pix_en = en;
        @(posedge clk);
        if (rst_n && en) begin
            k++;
            last = 1'b1;
        end else begin
            last = 1'b0;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        bit found;
        pix_en = 1'b0;
        k      = 0;
        last   = 1'b0;
        n_vec  = 0;
        n_err  = 0;

        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        repeat (3) tick(1'b0);

        // Continuous strobe: many default lines, many small-raster frames.
        repeat (32000) tick(1'b1);

        // One strobe in four.
        for (int i = 0; i < 4000; i++) tick((i % 4) == 0);

        // Random strobe density.
        for (int i = 0; i < 8000; i++) begin
            if (i < 4000) tick($urandom_range(0, 2) == 0);
            else          tick($urandom_range(0, 3) != 0);
        end

        // Seek x=300 on the default raster, then reset asynchronously.
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (k > 0 && ((k - 1) % 800) == 300) begin
                found = 1'b1;
                break;
            end
            tick(1'b1);
        end
        chk("seek_x300", found, 1'b1);

        #2;
        rst_n = 1'b0;
        k     = 0;
        last  = 1'b0;
        #1;
        check_all();
        repeat (3) tick(1'b1);
        rst_n = 1'b1;
        repeat (3000) tick(1'b1);
        repeat (3) tick(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the VGA output path. Free-running horizontal/vertical counters advance on a pixel-clock enable and produce registered `hsync_o`, `vsync_o`, `active_video_o` and pixel coordinates. These drive the PMOD VGA DAC stage and the pixel source that supplies its RGB inputs. An optional colour-bar pattern lets the display path be brought up with no frame buffer.

## Interface
- `H_ACTIVE`, 640, visible pixels per line; must be a multiple of 8
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HSYNC_POL`, 1'b0, asserted level of hsync (0 = active-low)
- `VSYNC_POL`, 1'b0, asserted level of vsync
- `clk_i`  in  1  system clock; single clock domain
- `rst_ni`  in  1  reset, asynchronous, active-low
- `pix_en_i`  in  1  pixel strobe; one pixel advance per clock with `pix_en_i`=1
- `hsync_o`  out  1  horizontal sync, polarity per `HSYNC_POL`
- `vsync_o`  out  1  vertical sync, polarity per `VSYNC_POL`
- `active_video_o`  out  1  current pixel is visible
- `x_o`  out  XW  horizontal count, XW = $clog2(H_TOTAL)
- `y_o`  out  YW  vertical count, YW = $clog2(V_TOTAL)
- `line_start_o`  out  1  one-clock pulse, x = 0
- `frame_start_o`  out  1  one-clock pulse, x = 0 and y = 0
- `pat_r_o`, `pat_g_o`, `pat_b_o`  out  4 each  colour-bar pattern

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal `h_cnt` counts 0..H_TOTAL-1. `v_cnt` counts 0..V_TOTAL-1. Both advance only on clocks with `pix_en_i`=1.
- At h_cnt = H_TOTAL-1, `h_cnt` wraps to 0 and `v_cnt` increments. At v_cnt = V_TOTAL-1 as well, `v_cnt` wraps to 0.
- Per-axis region order: active, front porch, sync, back porch.
- Visible when h < H_ACTIVE and v < V_ACTIVE.
- hsync is asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- vsync is asserted for lines 490..491, over the full line regardless of h.
- `x_o` and `y_o` give the raw counter values over the full range. Consumers qualify them with `active_video_o`.
- With `pix_en_i`=0 every register holds. Pulse outputs are cleared on the next clock.

## Timing
- On each `pix_en_i`=1 edge, all outputs are registered from the current (h, v), then the counters advance. All outputs are mutually aligned, one clock after the counter value.
- Level outputs hold between strobes. `line_start_o` and `frame_start_o` are high for exactly one clock after the qualifying strobe edge.
- Reset values:
  - h_cnt = v_cnt = 0, x_o = y_o = 0
  - `active_video_o` = 0, pulses = 0, pattern = 0
  - `hsync_o` = ~HSYNC_POL, `vsync_o` = ~VSYNC_POL
- The first strobe after reset release emits pixel (0,0) with `active_video_o`=1 and `frame_start_o`=1.
- Reset asserted mid-frame clears immediately (asynchronous). The next frame restarts at (0,0); there is no partial-line recovery.
- `pix_en_i` held high every clock is legal, giving one pixel per clock.

## Configuration
- `VGA_TIMING_PATTERN_EN` defined: 8 vertical bars, each H_ACTIVE/8 wide. Order is white, yellow, cyan, green, magenta, red, blue, black. Each channel is 4'hF or 4'h0.
- The pattern is registered with the other outputs and is 0 whenever `active_video_o`=0.
- The bar index comes from a bar counter that clears at h=0 and steps every H_ACTIVE/8 pixels. No divider.
- Undefined: pattern ports stay present and are tied to 4'h0; no bar logic is built.

## Structure
- Shared package `vga_pkg` holds:
  - 640x480@60 timing localparams
  - `rgb444_t` packed struct {r, g, b}
  - bar colour constant array
- Sub-module `vga_axis_counter`, instantiated twice (h with inc = `pix_en_i`; v with inc = h wrap):
  - parameters: ACTIVE/FP/SYNC/BP
  - outputs: count, active, sync (unpolarised), wrap
- Elaboration-time assertions in the top level: H_ACTIVE % 8 == 0; every porch and sync width ≥ 1.

## Test plan
- Reset, then `pix_en_i`=1 continuously. Expect `frame_start_o` on the 1st output clock, then every 420000 clocks. Expect `line_start_o` every 800 clocks.
- One line: `active_video_o` high for 640 clocks, then low for 160. Expect `hsync_o`=0 for output x = 656..751 and 1 elsewhere.
- One frame: `vsync_o`=0 exactly for y = 490..491, i.e. 1600 output clocks. Expect `active_video_o`=0 for all y ≥ 480.
- `pix_en_i` asserted 1 clock in 4. Expect line period 3200 clocks, outputs stable across the 3 idle clocks, and pulses exactly 1 clock wide.
- Assert `rst_ni`=0 asynchronously at (x=300, y=200). Expect outputs at reset values without waiting for a clock edge. After release, expect the first strobe to give x=0, y=0, `frame_start_o`=1.
- With `VGA_TIMING_PATTERN_EN`:
  - x=0..79 gives RGB F/F/F
  - x=80 gives F/F/0
  - x=560..639 gives 0/0/0
  - blanking gives 0/0/0
  - without the macro, always 0
